dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Load/store-side initiator for the byte-enabled data SRAM: accepts one CPU load/store request at a time over a valid/ready handshake and drives the SRAM chip-select, write-enable, byte-enable, word address and write data. It returns load data aligned to bit 0 and sign- or zero-extended. It sits between the LSU and the data SRAM macro (`csn`/`wen` active-low, `ben` active-high, 1-cycle registered-address read).

## Interface
- `AW`, 16, SRAM word-address width; the byte address is `AW+2` bits.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned` in 1: zero-extend loads when set, sign-extend when clear.
- `req_addr` in AW+2: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: formatted load data; 0 for stores.
- `rsp_err` out 1: misaligned access (see Configuration).
- `csn` out 1: SRAM chip select, active-low.
- `wen` out 1: SRAM write enable, active-low.
- `ben` out 4: SRAM byte enables.
- `addr` out AW: SRAM word address, `req_addr[AW+1:2]`.
- `din` out 32: SRAM write data.
- `dout` in 32: SRAM read data, valid the cycle after a read strobe.

## Operation
- **FSM states:** IDLE, RD, RSP.
- **Ports in IDLE:**
  - `req_ready`=1.
  - On `req_valid`, the SRAM strobe is driven combinationally in the same cycle: `csn`=0, `wen`=~`req_wr`, `addr`, `ben`, `din`.
  - Load → RD. Store → RSP.
- **RD:**
  - `csn`=1.
  - `dout` is formatted and registered into `rsp_rdata`, with `rsp_err`=0.
  - → RSP.
- **RSP:**
  - `rsp_valid`=1; data is held stable.
  - On `rsp_ready` → IDLE.
  - `req_ready`=0; there is no overlap (one outstanding transaction).
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`.
  - half: `4'b0011 << {addr[1],1'b0}`.
  - word: `4'b1111`.
- **`din` lane replication:** byte value replicated ×4, half replicated ×2, word passed through.
- **Load formatting:** select the lane(s) from `req_addr[1:0]`, captured at issue. Extend from bit 7 (byte) or bit 15 (half); the `req_unsigned` setting is used.
- **Misaligned accesses** (half with `addr[0]`=1; word with `addr[1:0]`≠0): see Configuration.
- **SRAM outputs when not strobing:** `csn`=1, `wen`=1, `ben`=0, `din`=0, `addr` holds its last value.

## Timing
- Load: request accepted in cycle 0 → `rsp_valid` from cycle 2.
- Store: SRAM write at the cycle-0 edge → `rsp_valid` from cycle 1.
- Minimum request spacing: 3 cycles for a load, 2 for a store, with `rsp_ready` held high.
- **During reset:**
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `req_ready`=0.
  - `csn`=1, `wen`=1, `ben`=0, `din`=0, `addr`=0.
  - FSM = IDLE.
- **Reset asserted mid-transaction:** the transaction is dropped and outputs go to their reset values immediately. A store whose edge has already passed remains written.
- **`rsp_valid` with `rsp_ready` low:** response held indefinitely; `rsp_valid` is never deasserted without a handshake.

## Configuration
- **`DMEM_MISALIGN_TRAP_EN` defined:**
  - No SRAM strobe is issued; `csn` stays 1.
  - FSM goes IDLE → RSP with `rsp_err`=1 and `rsp_rdata`=0; store data is discarded.
- **`DMEM_MISALIGN_TRAP_EN` undefined:**
  - Misaligned low address bits are forced to the natural alignment (half: `addr[0]`=0; word: `addr[1:0]`=0).
  - The access proceeds normally.
  - `rsp_err` is tied 0.

## Structure
- **Package `dmem_pkg`:**
  - Size encodings `SZ_B`, `SZ_H`, `SZ_W`.
  - FSM state enum (IDLE/RD/RSP).
  - `ben` generation function.
- **Sub-module `dmem_load_fmt`:** combinational lane select plus sign/zero extension; inputs are `dout`, offset, size and unsigned.

## Test plan
- **Word store then load:** store word `0xDEADBEEF` @0x0010 → `ben`=1111, `din`=DEADBEEF, `addr`=4. Load word @0x0010 → `rsp_rdata`=DEADBEEF in cycle 2.
- **Byte store:** store byte `0x80` @0x0013 → `ben`=1000, `din`=80808080. Load byte signed @0x0013 → FFFFFF80; unsigned → 00000080.
- **Half load:** load half @0x0012 with memory word `0x8001_7FFF` → signed FFFF8001; load half @0x0010 → 00007FFF.
- **Misaligned:** load word @0x0011.
  - With the macro: `csn` stays 1 and `rsp_err`=1 at cycle 1.
  - Without it: access at `addr`=4, `rsp_err`=0.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid` → data stable, `req_ready`=0. Release → `req_ready`=1 in the next cycle.
- **Reset mid-load:** `rst` pulsed while in RD → `rsp_valid` never asserts, `csn`=1. The next load after reset completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-SRAM load/store controller:
// size encodings, FSM state type and byte-enable / alignment helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RSP
    } state_t;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] ben_gen(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    ben_gen = 4'b0001 << off;
            SZ_H:    ben_gen = 4'b0011 << {off[1], 1'b0};
            default: ben_gen = 4'b1111;
        endcase
    endfunction

    // True when the offset is not naturally aligned for the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Load data formatter: picks the addressed byte/half lane out of the SRAM
// word, moves it to bit 0 and sign- or zero-extends it.
module dmem_load_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select followed by extension from bit 7 or bit 15.
    always_comb begin
        byte_v = dout[{off, 3'b000} +: 8];
        half_v = dout[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    rdata = {{24{byte_v[7] & ~uns}}, byte_v};
            SZ_H:    rdata = {{16{half_v[15] & ~uns}}, half_v};
            default: rdata = dout;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-SRAM load/store initiator. One transaction at a time over a
// valid/ready request channel; strobes the SRAM combinationally on accept
// and returns formatted load data one cycle after the registered read.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (trap misaligned accesses
// with rsp_err instead of silently aligning them).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW+1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          csn,
    output logic          wen,
    output logic [3:0]    ben,
    output logic [AW-1:0] addr,
    output logic [31:0]   din,
    input  logic [31:0]   dout
);

    state_t        state_q, state_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW-1:0] addr_q, addr_d;

    logic [1:0]    eff_off;
    logic          trap;
    logic [31:0]   fmt_rdata;

    dmem_load_fmt u_fmt (
        .dout  (dout),
        .off   (off_q),
        .size  (size_q),
        .uns   (uns_q),
        .rdata (fmt_rdata)
    );

    // Decide whether the incoming request traps or which offset it really uses.
    always_comb begin
        eff_off = req_addr[1:0];
        trap    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        trap    = misaligned(req_size, req_addr[1:0]);
`else
        case (req_size)
            SZ_B:    eff_off = req_addr[1:0];
            SZ_H:    eff_off = {req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
`endif
    end

    // Next-state, SRAM strobe and handshake outputs; rst gates the
    // combinational strobe so reset values appear on the pins immediately.
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        off_d     = off_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        csn       = 1'b1;
        wen       = 1'b1;
        ben       = '0;
        din       = '0;
        addr      = addr_q;
        case (state_q)
            IDLE: begin
                req_ready = ~rst;
                if (req_valid && !rst) begin
                    if (trap) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RSP;
                    end else begin
                        csn     = 1'b0;
                        wen     = ~req_wr;
                        ben     = ben_gen(req_size, eff_off);
                        addr    = req_addr[AW+1:2];
                        addr_d  = req_addr[AW+1:2];
                        case (req_size)
                            SZ_B:    din = {4{req_wdata[7:0]}};
                            SZ_H:    din = {2{req_wdata[15:0]}};
                            default: din = req_wdata;
                        endcase
                        off_d   = eff_off;
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = req_wr ? RSP : RD;
                    end
                end
            end
            RD: begin
                rdata_d = fmt_rdata;
                err_d   = 1'b0;
                state_d = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // State and captured-request registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a behavioural SRAM model
// and a response scoreboard.
module tb_dmem_ctrl;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          csn;
    logic          wen;
    logic [3:0]    ben;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [31:0]   dout = '0;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_rd_q[$];
    logic        exp_err_q[$];

    logic [31:0] mem [0:255];

    dmem_ctrl #(.AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .csn          (csn),
        .wen          (wen),
        .ben          (ben),
        .addr         (addr),
        .din          (din),
        .dout         (dout)
    );

    always #5 clk = ~clk;

    // SRAM model: byte-enabled write, registered-address read.
    always @(posedge clk) begin
        if (!csn) begin
            if (!wen) begin
                for (int b = 0; b < 4; b++)
                    if (ben[b]) mem[addr[7:0]][8*b +: 8] <= din[8*b +: 8];
            end else begin
                dout <= mem[addr[7:0]];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request with rsp_ready high, check the strobe, latency and response.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [17:0] a, input logic [31:0] wd,
                          input logic ecsn, input logic [3:0] eben, input logic [31:0] edin,
                          input logic [15:0] eaddr, input logic [31:0] erd,
                          input logic eerr, input int elat);
        int n;
        logic [31:0] xr;
        logic        xe;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        #1;
        chk("csn", {31'd0, csn}, {31'd0, ecsn});
        chk("wen", {31'd0, wen}, {31'd0, ecsn ? 1'b1 : ~wr});
        chk("ben", {28'd0, ben}, {28'd0, eben});
        chk("din", din, edin);
        chk("addr", {16'd0, addr}, {16'd0, eaddr});
        exp_rd_q.push_back(erd);
        exp_err_q.push_back(eerr);
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = '0;
        n = 1;
        while (!rsp_valid && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, elat);
        xr = exp_rd_q.pop_front();
        xe = exp_err_q.pop_front();
        chk("rsp_rdata", rsp_rdata, xr);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, xe});
        @(posedge clk); #1;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] xr;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset values
        #12;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_csn", {31'd0, csn}, 32'd1);
        chk("rst_wen", {31'd0, wen}, 32'd1);
        chk("rst_ben", {28'd0, ben}, 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_addr", {16'd0, addr}, 32'd0);
        #5 rst = 1'b0;
        @(posedge clk); #1;

        // Word store then load
        do_req(1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 16'd4, 32'h0, 1'b0, 1);
        do_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 1'b0, 4'b1111, 32'h0, 16'd4, 32'hDEADBEEF, 1'b0, 2);
        // Byte store, signed/unsigned byte loads
        do_req(1'b1, 2'b00, 1'b0, 18'h00013, 32'h12345680, 1'b0, 4'b1000, 32'h80808080, 16'd4, 32'h0, 1'b0, 1);
        do_req(1'b0, 2'b00, 1'b0, 18'h00013, 32'h0, 1'b0, 4'b1000, 32'h0, 16'd4, 32'hFFFFFF80, 1'b0, 2);
        do_req(1'b0, 2'b00, 1'b1, 18'h00013, 32'h0, 1'b0, 4'b1000, 32'h0, 16'd4, 32'h00000080, 1'b0, 2);
        // Half loads from 0x8001_7FFF
        do_req(1'b1, 2'b11, 1'b0, 18'h00010, 32'h80017FFF, 1'b0, 4'b1111, 32'h80017FFF, 16'd4, 32'h0, 1'b0, 1);
        do_req(1'b0, 2'b01, 1'b0, 18'h00012, 32'h0, 1'b0, 4'b1100, 32'h0, 16'd4, 32'hFFFF8001, 1'b0, 2);
        do_req(1'b0, 2'b01, 1'b0, 18'h00010, 32'h0, 1'b0, 4'b0011, 32'h0, 16'd4, 32'h00007FFF, 1'b0, 2);
        // Misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(1'b0, 2'b10, 1'b0, 18'h00011, 32'h0, 1'b1, 4'b0000, 32'h0, 16'd4, 32'h0, 1'b1, 1);
`else
        do_req(1'b0, 2'b10, 1'b0, 18'h00011, 32'h0, 1'b0, 4'b1111, 32'h0, 16'd4, 32'h80017FFF, 1'b0, 2);
`endif
        // Half store replication, then byte load from it
        do_req(1'b1, 2'b01, 1'b0, 18'h00022, 32'h0000A5C3, 1'b0, 4'b1100, 32'hA5C3A5C3, 16'd8, 32'h0, 1'b0, 1);
        do_req(1'b0, 2'b00, 1'b1, 18'h00023, 32'h0, 1'b0, 4'b1000, 32'h0, 16'd8, 32'h000000A5, 1'b0, 2);

        // Backpressure: response held while rsp_ready is low
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b01; req_unsigned = 1'b1; req_addr = 18'h00012;
        exp_rd_q.push_back(32'h00008001);
        exp_err_q.push_back(1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        xr = exp_rd_q.pop_front();
        void'(exp_err_q.pop_front());
        chk("bp_rdata", rsp_rdata, xr);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_hold_rdata", rsp_rdata, xr);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset pulsed while in RD
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_addr = 18'h00010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_csn", {31'd0, csn}, 32'd1);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rst_addr", {16'd0, addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("post_rst_csn", {31'd0, csn}, 32'd1);
            @(posedge clk); #1;
        end
        do_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 1'b0, 4'b1111, 32'h0, 16'd4, 32'h80017FFF, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
